// File: rtl/alu_core_if.sv
// ALU stimulus/monitor interface: operands, command and control flow
// towards the ALU, registered results and flags flow back.
interface alu_core_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic           CE;
    logic           MODE;
    logic [M-1:0]   CMD;
    logic [1:0]     INP_VALID;
    logic [N-1:0]   OPA;
    logic [N-1:0]   OPB;
    logic           CIN;
    logic [N:0]     RES;
    logic           COUT;
    logic           OFLOW;
    logic           G;
    logic           L;
    logic           E;
    logic           ERR;

    modport master (
        output CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        input  RES, COUT, OFLOW, G, L, E, ERR
    );

    modport slave (
        input  CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        output RES, COUT, OFLOW, G, L, E, ERR
    );
endinterface

// File: rtl/alu_core.sv
// Sequential ALU responder. Operands may arrive together or in separate
// cycles; a two-operand command missing one operand waits a bounded number
// of cycles for it. Results and flags are registered.
module alu_core #(
    parameter int N           = 8,
    parameter int M           = 4,
    parameter int WAIT_CYCLES = 16
) (
    input  logic      CLK,
    input  logic      RST,
    alu_core_if.slave bus
);
    localparam int LOG = $clog2(N);
    localparam int CW  = $clog2(WAIT_CYCLES + 1);
    localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    typedef struct packed {
        logic [N:0] res;
        logic       cout;
        logic       oflow;
        logic       g;
        logic       l;
        logic       e;
        logic       err;
    } result_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    cmd_q, cmd_d;
    logic            mode_q, mode_d;
    logic            cin_q, cin_d;
    logic [N-1:0]    opr_q, opr_d;
    logic            haveA_q, haveA_d;
    result_t         out_q, out_d;

    logic            opLegal, opNeedA, opNeedB;
    logic            waitArrive;
    result_t         idleRes, waitRes;

    // Error outcome: result zero, every flag except ERR cleared.
    function automatic result_t errResult();
        result_t r;
        r     = '0;
        r.err = 1'b1;
        return r;
    endfunction

    // Classify a command: {legal, needs A, needs B}.
    function automatic logic [2:0] opNeeds(input logic mode, input logic [M-1:0] cmd);
        int c;
        c = int'(cmd);
        opNeeds = 3'b000;
        if (mode) begin
            case (c)
                0, 1, 2, 3, 8: opNeeds = 3'b111;
                4, 5:          opNeeds = 3'b110;
                6, 7:          opNeeds = 3'b101;
                default:       opNeeds = 3'b000;
            endcase
        end else begin
            case (c)
                0, 1, 2, 3, 4, 5, 12, 13: opNeeds = 3'b111;
                6, 8, 9:                  opNeeds = 3'b110;
                7, 10, 11:                opNeeds = 3'b101;
                default:                  opNeeds = 3'b000;
            endcase
        end
    endfunction

    // The ALU datapath proper: every flag not produced by the op stays 0.
    function automatic result_t compute(input logic mode, input logic [M-1:0] cmd,
                                        input logic cin, input logic [N-1:0] a,
                                        input logic [N-1:0] b);
        result_t        r;
        logic [N:0]     ax, bx, cx;
        logic [2*N-1:0] rot;
        int             c;
        r   = '0;
        ax  = {1'b0, a};
        bx  = {1'b0, b};
        cx  = {{N{1'b0}}, cin};
        rot = '0;
        c   = int'(cmd);
        if (mode) begin
            case (c)
                0: begin r.res = ax + bx;      r.cout  = r.res[N];        end
                1: begin r.res = ax - bx;      r.oflow = (a < b);         end
                2: begin r.res = ax + bx + cx; r.cout  = r.res[N];        end
                3: begin r.res = ax - bx - cx; r.oflow = (ax < (bx + cx)); end
                4: begin r.res = ax + ONE;     r.cout  = r.res[N];        end
                5: begin r.res = ax - ONE;     r.oflow = (a == '0);       end
                6: begin r.res = bx + ONE;     r.cout  = r.res[N];        end
                7: begin r.res = bx - ONE;     r.oflow = (b == '0);       end
                8: begin r.g = (a > b); r.l = (a < b); r.e = (a == b);    end
                default: r = errResult();
            endcase
        end else begin
            case (c)
                0:  r.res = {1'b0, a & b};
                1:  r.res = {1'b0, ~(a & b)};
                2:  r.res = {1'b0, a | b};
                3:  r.res = {1'b0, ~(a | b)};
                4:  r.res = {1'b0, a ^ b};
                5:  r.res = {1'b0, ~(a ^ b)};
                6:  r.res = {1'b0, ~a};
                7:  r.res = {1'b0, ~b};
                8:  r.res = {1'b0, a >> 1};
                9:  r.res = {1'b0, a << 1};
                10: r.res = {1'b0, b >> 1};
                11: r.res = {1'b0, b << 1};
                12: begin
                    if (|b[N-1:LOG+1]) begin
                        r = errResult();
                    end else begin
                        rot   = {a, a} << b[LOG-1:0];
                        r.res = {1'b0, rot[2*N-1:N]};
                    end
                end
                13: begin
                    if (|b[N-1:LOG+1]) begin
                        r = errResult();
                    end else begin
                        rot   = {a, a} >> b[LOG-1:0];
                        r.res = {1'b0, rot[N-1:0]};
                    end
                end
                default: r = errResult();
            endcase
        end
        return r;
    endfunction

    // Decode the incoming command and precompute both candidate results.
    always_comb begin
        {opLegal, opNeedA, opNeedB} = opNeeds(bus.MODE, bus.CMD);
        idleRes    = compute(bus.MODE, bus.CMD, bus.CIN, bus.OPA, bus.OPB);
        waitRes    = compute(mode_q, cmd_q, cin_q,
                             haveA_q ? opr_q : bus.OPA,
                             haveA_q ? bus.OPB : opr_q);
        waitArrive = haveA_q ? bus.INP_VALID[1] : bus.INP_VALID[0];
    end

    // Next-state logic: operand collection, timeout and result selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        opr_d   = opr_q;
        haveA_d = haveA_q;
        out_d   = out_q;
        if (bus.CE) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.INP_VALID != 2'b00) begin
                        if (!opLegal) begin
                            out_d = errResult();
                        end else if (opNeedA && opNeedB) begin
                            if (bus.INP_VALID == 2'b11) begin
                                out_d = idleRes;
                            end else begin
                                state_d = ST_WAIT;
                                cnt_d   = '0;
                                cmd_d   = bus.CMD;
                                mode_d  = bus.MODE;
                                cin_d   = bus.CIN;
                                haveA_d = bus.INP_VALID[0];
                                opr_d   = bus.INP_VALID[0] ? bus.OPA : bus.OPB;
                            end
                        end else if ((opNeedA && bus.INP_VALID[0]) ||
                                     (opNeedB && bus.INP_VALID[1])) begin
                            out_d = idleRes;
                        end else begin
                            out_d = errResult();
                        end
                    end
                end
                ST_WAIT: begin
                    if (waitArrive) begin
                        out_d   = waitRes;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
                        out_d   = errResult();
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, latched operands and registered outputs; reset clears everything.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            opr_q   <= '0;
            haveA_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            opr_q   <= opr_d;
            haveA_q <= haveA_d;
            out_q   <= out_d;
        end
    end

    assign bus.RES   = out_q.res;
    assign bus.COUT  = out_q.cout;
    assign bus.OFLOW = out_q.oflow;
    assign bus.G     = out_q.g;
    assign bus.L     = out_q.l;
    assign bus.E     = out_q.e;
    assign bus.ERR   = out_q.err;
endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: a table of single-cycle vectors followed by
// hand-written sequences for split operands, timeout, clock enable and reset.
module tb_alu_core;
    localparam int N           = 8;
    localparam int M           = 4;
    localparam int WAIT_CYCLES = 16;

    // Expected outputs: result then flags {COUT, OFLOW, G, L, E, ERR}.
    typedef struct packed {
        logic [N:0] res;
        logic [5:0] flags;
    } exp_t;

    typedef struct {
        logic         mode;
        logic [M-1:0] cmd;
        logic [1:0]   valid;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        exp_t         expOut;
    } vec_t;

    logic clk = 1'b0;
    logic rstN;
    int   applied     = 0;
    int   miscompares = 0;
    vec_t vecs[$];

    alu_core_if #(.N(N), .M(M)) bus();

    alu_core #(.N(N), .M(M), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .CLK (clk),
        .RST (rstN),
        .bus (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic exp_t ex(input logic [N:0] r, input logic [5:0] f);
        exp_t e;
        e.res   = r;
        e.flags = f;
        return e;
    endfunction

    function automatic vec_t mk(input logic mode, input logic [M-1:0] cmd,
                                input logic [1:0] valid, input logic [N-1:0] a,
                                input logic [N-1:0] b, input logic cin, input exp_t e);
        vec_t v;
        v.mode   = mode;
        v.cmd    = cmd;
        v.valid  = valid;
        v.a      = a;
        v.b      = b;
        v.cin    = cin;
        v.expOut = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.MODE      = v.mode;
        bus.CMD       = v.cmd;
        bus.INP_VALID = v.valid;
        bus.OPA       = v.a;
        bus.OPB       = v.b;
        bus.CIN       = v.cin;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.INP_VALID = 2'b00;
            tick();
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t expOut);
        exp_t got;
        got.res   = bus.RES;
        got.flags = {bus.COUT, bus.OFLOW, bus.G, bus.L, bus.E, bus.ERR};
        applied++;
        if (got !== expOut) begin
            miscompares++;
            $display("[TB] FAIL %s: got RES=%h flags=%b, expected RES=%h flags=%b",
                     tag, got.res, got.flags, expOut.res, expOut.flags);
        end
    endtask

    initial begin
        // flags order: COUT OFLOW G L E ERR
        vecs.push_back(mk(1, 0,  2'b11, 8'hFF, 8'h01, 0, ex(9'h100, 6'b100000)));
        vecs.push_back(mk(1, 1,  2'b11, 8'h03, 8'h05, 0, ex(9'h1FE, 6'b010000)));
        vecs.push_back(mk(1, 0,  2'b00, 8'h55, 8'h55, 0, ex(9'h1FE, 6'b010000)));
        vecs.push_back(mk(1, 8,  2'b11, 8'h03, 8'h05, 0, ex(9'h000, 6'b000100)));
        vecs.push_back(mk(1, 8,  2'b11, 8'h07, 8'h07, 0, ex(9'h000, 6'b000010)));
        vecs.push_back(mk(1, 8,  2'b11, 8'h09, 8'h02, 0, ex(9'h000, 6'b001000)));
        vecs.push_back(mk(1, 2,  2'b11, 8'h10, 8'h20, 1, ex(9'h031, 6'b000000)));
        vecs.push_back(mk(1, 2,  2'b11, 8'hFF, 8'hFF, 1, ex(9'h1FF, 6'b100000)));
        vecs.push_back(mk(1, 3,  2'b11, 8'h10, 8'h10, 1, ex(9'h1FF, 6'b010000)));
        vecs.push_back(mk(1, 3,  2'b11, 8'h20, 8'h10, 1, ex(9'h00F, 6'b000000)));
        vecs.push_back(mk(1, 1,  2'b11, 8'h05, 8'h03, 1, ex(9'h002, 6'b000000)));
        vecs.push_back(mk(1, 4,  2'b01, 8'hFF, 8'h00, 0, ex(9'h100, 6'b100000)));
        vecs.push_back(mk(1, 5,  2'b01, 8'h00, 8'h00, 0, ex(9'h1FF, 6'b010000)));
        vecs.push_back(mk(1, 6,  2'b10, 8'h00, 8'h7F, 0, ex(9'h080, 6'b000000)));
        vecs.push_back(mk(1, 7,  2'b10, 8'h00, 8'h05, 0, ex(9'h004, 6'b000000)));
        vecs.push_back(mk(1, 4,  2'b11, 8'h41, 8'h00, 0, ex(9'h042, 6'b000000)));
        vecs.push_back(mk(1, 4,  2'b10, 8'h00, 8'h05, 0, ex(9'h000, 6'b000001)));
        vecs.push_back(mk(1, 9,  2'b11, 8'h01, 8'h01, 0, ex(9'h000, 6'b000001)));
        vecs.push_back(mk(1, 15, 2'b11, 8'h01, 8'h01, 0, ex(9'h000, 6'b000001)));
        vecs.push_back(mk(0, 0,  2'b11, 8'hF0, 8'h3C, 0, ex(9'h030, 6'b000000)));
        vecs.push_back(mk(0, 1,  2'b11, 8'hF0, 8'h3C, 0, ex(9'h0CF, 6'b000000)));
        vecs.push_back(mk(0, 2,  2'b11, 8'hF0, 8'h3C, 0, ex(9'h0FC, 6'b000000)));
        vecs.push_back(mk(0, 3,  2'b11, 8'hF0, 8'h3C, 0, ex(9'h003, 6'b000000)));
        vecs.push_back(mk(0, 4,  2'b11, 8'hF0, 8'h3C, 0, ex(9'h0CC, 6'b000000)));
        vecs.push_back(mk(0, 5,  2'b11, 8'hF0, 8'h3C, 0, ex(9'h033, 6'b000000)));
        vecs.push_back(mk(0, 6,  2'b01, 8'h0F, 8'h00, 0, ex(9'h0F0, 6'b000000)));
        vecs.push_back(mk(0, 7,  2'b10, 8'h00, 8'hAA, 0, ex(9'h055, 6'b000000)));
        vecs.push_back(mk(0, 7,  2'b01, 8'hAA, 8'h00, 0, ex(9'h000, 6'b000001)));
        vecs.push_back(mk(0, 8,  2'b01, 8'h81, 8'h00, 0, ex(9'h040, 6'b000000)));
        vecs.push_back(mk(0, 9,  2'b01, 8'h81, 8'h00, 0, ex(9'h002, 6'b000000)));
        vecs.push_back(mk(0, 10, 2'b10, 8'h00, 8'h03, 0, ex(9'h001, 6'b000000)));
        vecs.push_back(mk(0, 11, 2'b10, 8'h00, 8'hC0, 0, ex(9'h080, 6'b000000)));
        vecs.push_back(mk(0, 12, 2'b11, 8'h81, 8'h01, 0, ex(9'h003, 6'b000000)));
        vecs.push_back(mk(0, 13, 2'b11, 8'h81, 8'h01, 0, ex(9'h0C0, 6'b000000)));
        vecs.push_back(mk(0, 12, 2'b11, 8'h81, 8'h10, 0, ex(9'h000, 6'b000001)));
        vecs.push_back(mk(0, 13, 2'b11, 8'h81, 8'h07, 0, ex(9'h003, 6'b000000)));
        vecs.push_back(mk(0, 12, 2'b11, 8'h81, 8'h80, 0, ex(9'h000, 6'b000001)));
        vecs.push_back(mk(0, 15, 2'b11, 8'h01, 8'h01, 0, ex(9'h000, 6'b000001)));
        vecs.push_back(mk(0, 14, 2'b01, 8'h01, 8'h01, 0, ex(9'h000, 6'b000001)));

        bus.CE = 1'b1;
        applyStimulus(mk(0, 0, 2'b00, 8'h00, 8'h00, 0, ex(9'h000, 6'b000000)));
        rstN = 1'b0;
        #12;
        checkOutput("reset", ex(9'h000, 6'b000000));
        rstN = 1'b1;

        // Back-to-back table vectors, one result per cycle.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].expOut);
        end

        // Split XOR: A now, B after 5 idle cycles; CMD/MODE/OPA changes ignored.
        applyStimulus(mk(1, 0, 2'b11, 8'h01, 8'h01, 0, '0));
        tick();
        checkOutput("s1_pre", ex(9'h002, 6'b000000));
        applyStimulus(mk(0, 4, 2'b01, 8'hF0, 8'h00, 0, '0));
        tick();
        checkOutput("s1_partial_hold", ex(9'h002, 6'b000000));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mk(1, 1, 2'b00, 8'h55, 8'hAA, 1, '0));
            tick();
            checkOutput($sformatf("s1_wait%0d_hold", i), ex(9'h002, 6'b000000));
        end
        applyStimulus(mk(1, 1, 2'b10, 8'h55, 8'h0F, 1, '0));
        tick();
        checkOutput("s1_done", ex(9'h0FF, 6'b000000));

        // Timeout: B only, then nothing for WAIT_CYCLES cycles.
        applyStimulus(mk(1, 0, 2'b10, 8'h00, 8'h05, 0, '0));
        tick();
        idleCycles(WAIT_CYCLES - 1);
        checkOutput("s2_before_timeout", ex(9'h0FF, 6'b000000));
        idleCycles(1);
        checkOutput("s2_timeout", ex(9'h000, 6'b000001));
        applyStimulus(mk(1, 0, 2'b01, 8'h03, 8'h00, 0, '0));
        tick();
        checkOutput("s2_late_not_taken", ex(9'h000, 6'b000001));
        applyStimulus(mk(1, 0, 2'b10, 8'h00, 8'h01, 0, '0));
        tick();
        checkOutput("s2_new_pair", ex(9'h004, 6'b000000));

        // Boundary: missing A arrives on the last allowed wait cycle.
        applyStimulus(mk(1, 0, 2'b10, 8'h00, 8'h05, 0, '0));
        tick();
        idleCycles(WAIT_CYCLES - 1);
        applyStimulus(mk(1, 0, 2'b01, 8'h03, 8'h00, 0, '0));
        tick();
        checkOutput("s3_boundary_accept", ex(9'h008, 6'b000000));

        // Clock enable low freezes the wait; B offered while frozen is ignored.
        applyStimulus(mk(1, 1, 2'b01, 8'h09, 8'h00, 0, '0));
        tick();
        idleCycles(2);
        bus.CE = 1'b0;
        applyStimulus(mk(1, 1, 2'b10, 8'h00, 8'h01, 0, '0));
        for (int i = 0; i < 20; i++) tick();
        checkOutput("s4_frozen_hold", ex(9'h008, 6'b000000));
        bus.CE = 1'b1;
        applyStimulus(mk(1, 1, 2'b10, 8'h00, 8'h04, 0, '0));
        tick();
        checkOutput("s4_after_freeze", ex(9'h005, 6'b000000));
        bus.CE = 1'b0;
        applyStimulus(mk(1, 0, 2'b11, 8'h01, 8'h01, 0, '0));
        tick();
        checkOutput("s4_ce_low_full_op", ex(9'h005, 6'b000000));
        bus.CE = 1'b1;

        // Asynchronous reset mid-WAIT; the old op must not complete afterwards.
        applyStimulus(mk(1, 0, 2'b01, 8'h11, 8'h00, 0, '0));
        tick();
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("s5_async_reset", ex(9'h000, 6'b000000));
        #1;
        rstN = 1'b1;
        applyStimulus(mk(1, 0, 2'b10, 8'h00, 8'h22, 0, '0));
        tick();
        checkOutput("s5_old_op_gone", ex(9'h000, 6'b000000));
        applyStimulus(mk(1, 0, 2'b01, 8'h01, 8'h00, 0, '0));
        tick();
        checkOutput("s5_new_pair", ex(9'h023, 6'b000000));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
